// File: rtl/counter_7_checker_if.sv
// Sample stream and status bundle between a counter-stream source and its checker.
//
// Handshake: the source presents q_in together with in_valid; the checker
// samples q_in on every rising clock edge where in_valid is 1 and never stalls
// the source (there is no ready). Edges with in_valid low are ignored.
// clr_stat is a level sampled on the rising edge, like in_valid.
interface counter_7_checker_if #(
  parameter int WIDTH  = 7,
  parameter int STAT_W = 8
);
  logic [WIDTH-1:0]  q_in;
  logic              in_valid;
  logic              clr_stat;
  logic              locked;
  logic              err;
  logic              err_sticky;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;
  logic [WIDTH-1:0]  expected;

  // Stream source / status consumer side
  modport master (
    output q_in, in_valid, clr_stat,
    input  locked, err, err_sticky, err_count, wrap_count, expected
  );

  // Checker side
  modport slave (
    input  q_in, in_valid, clr_stat,
    output locked, err, err_sticky, err_count, wrap_count, expected
  );
endinterface

// File: rtl/counter_7_checker.sv
// Receive-side checker for a free-running counter stream: locks onto a
// +1 (mod 2^WIDTH) sequence, flags breaks while locked, keeps saturating
// error/wrap statistics and re-acquires after a break.
module counter_7_checker #(
  parameter int WIDTH    = 7,
  parameter int LOCK_CNT = 2,
  parameter int STAT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  counter_7_checker_if.slave   bus,
  output logic [1:0]           state_o,
  output logic [3:0]           run_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // run only has to reach LOCK_CNT, which is at most 15
  localparam int RUN_W = 4;
  localparam logic [WIDTH-1:0]  ONE_W    = 1;
  localparam logic [STAT_W-1:0] ONE_S    = 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  localparam logic [RUN_W-1:0]  LOCK_RUN = RUN_W'(LOCK_CNT);

  state_t            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [STAT_W-1:0] err_count_q, err_count_d;
  logic [STAT_W-1:0] wrap_count_q, wrap_count_d;

  logic [WIDTH-1:0]  q_plus1;
  logic              match;
  logic              err_ev;
  logic              wrap_ev;

  assign q_plus1 = bus.q_in + ONE_W;
  assign match   = (bus.q_in == expected_q);

  // State register plus all registered outputs; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      run_q        <= '0;
      expected_q   <= '0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      expected_q   <= expected_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  // Next-state: lock acquisition, tracking and break detection on valid samples
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    expected_d = expected_q;
    err_ev     = 1'b0;
    wrap_ev    = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        IDLE: begin
          expected_d = q_plus1;
          run_d      = '0;
          state_d    = SYNC;
        end
        SYNC: begin
          expected_d = q_plus1;
          if (match) begin
            if (run_q + 1'b1 == LOCK_RUN) begin
              run_d   = '0;
              state_d = LOCKED;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            // a break before lock only restarts the confirmation run
            run_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            expected_d = expected_q + ONE_W;
            wrap_ev    = (bus.q_in == '0);
          end else begin
            err_ev     = 1'b1;
            expected_d = q_plus1;
            run_d      = '0;
            state_d    = SYNC;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // Output next values: error pulse, sticky flag and saturating statistics
  always_comb begin
    locked_d = (state_d == LOCKED);
    err_d    = err_ev;

    // an event on the same edge as clr_stat wins over the clear
    if (err_ev)             err_sticky_d = 1'b1;
    else if (bus.clr_stat)  err_sticky_d = 1'b0;
    else                    err_sticky_d = err_sticky_q;

    if (err_ev) begin
      if (bus.clr_stat)                err_count_d = ONE_S;
      else if (err_count_q != STAT_MAX) err_count_d = err_count_q + ONE_S;
      else                             err_count_d = err_count_q;
    end else if (bus.clr_stat) begin
      err_count_d = '0;
    end else begin
      err_count_d = err_count_q;
    end

    if (wrap_ev) begin
      if (bus.clr_stat)                 wrap_count_d = ONE_S;
      else if (wrap_count_q != STAT_MAX) wrap_count_d = wrap_count_q + ONE_S;
      else                              wrap_count_d = wrap_count_q;
    end else if (bus.clr_stat) begin
      wrap_count_d = '0;
    end else begin
      wrap_count_d = wrap_count_q;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;
  assign bus.expected   = expected_q;

  assign state_o = state_q;
  assign run_o   = run_q;

endmodule

// File: tb/tb_counter_7_checker.sv
// Randomized and directed stimulus for counter_7_checker, checked against a
// sample-history reference model.
module tb_counter_7_checker;

  localparam int WIDTH    = 7;
  localparam int LOCK_CNT = 2;
  localparam int STAT_W   = 8;

  logic       clk;
  logic       reset;
  logic [1:0] state_o;
  logic [3:0] run_o;

  counter_7_checker_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus ();

  counter_7_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o),
    .run_o   (run_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the current unbroken +1 run of valid samples (newest last),
  // trimmed to LOCK_CNT+2 entries. The stream counts as locked once the run
  // holds more than LOCK_CNT samples (one seed plus LOCK_CNT confirmations).
  logic [WIDTH-1:0]  exp_q[$];
  logic              m_err;
  logic              m_sticky;
  int                m_errc;
  int                m_wrapc;
  localparam int     SAT = (1 << STAT_W) - 1;

  function automatic int sat_inc(input int v, input logic clr);
    if (clr) return 1;
    return (v < SAT) ? v + 1 : v;
  endfunction

  function automatic logic [WIDTH-1:0] m_expected();
    logic [WIDTH-1:0] t;
    if (exp_q.size() == 0) return '0;
    t = exp_q[$] + 1'b1;
    return t;
  endfunction

  task automatic model_edge(input logic rst, input logic v, input logic [WIDTH-1:0] q,
                            input logic clr);
    logic ev_err, ev_wrap, was_locked;
    logic [WIDTH-1:0] nxt;
    ev_err  = 1'b0;
    ev_wrap = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_err = 0; m_sticky = 0; m_errc = 0; m_wrapc = 0;
      return;
    end
    if (v) begin
      was_locked = (exp_q.size() > LOCK_CNT);
      nxt = m_expected();
      if (exp_q.size() != 0 && q != nxt) begin
        ev_err = was_locked;
        exp_q.delete();
        exp_q.push_back(q);
      end else begin
        ev_wrap = was_locked && (q == '0);
        exp_q.push_back(q);
        if (exp_q.size() > LOCK_CNT + 2) void'(exp_q.pop_front());
      end
    end
    m_err = ev_err;
    if (ev_err) m_errc = sat_inc(m_errc, clr);
    else if (clr) m_errc = 0;
    if (ev_wrap) m_wrapc = sat_inc(m_wrapc, clr);
    else if (clr) m_wrapc = 0;
    if (ev_err) m_sticky = 1'b1;
    else if (clr) m_sticky = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge, outputs are checked
  // 1 time unit after the edge that sampled them.
  task automatic step(input logic rst, input logic v, input logic [WIDTH-1:0] q,
                      input logic clr);
    reset        = rst;
    bus.in_valid = v;
    bus.q_in     = q;
    bus.clr_stat = clr;
    @(posedge clk);
    model_edge(rst, v, q, clr);
    #1;
    check("locked",     32'(bus.locked),     32'(exp_q.size() > LOCK_CNT));
    check("err",        32'(bus.err),        32'(m_err));
    check("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
    check("err_count",  32'(bus.err_count),  32'(m_errc));
    check("wrap_count", 32'(bus.wrap_count), 32'(m_wrapc));
    check("expected",   32'(bus.expected),   32'(m_expected()));
    if (rst) begin
      check("state_idle", 32'(state_o), 32'd0);
      check("run_zero",   32'(run_o),   32'd0);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] q);
    step(1'b0, 1'b1, q, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 7'($urandom_range(0, 127)), 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] bad;

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.q_in     = '0;
    bus.clr_stat = 1'b0;
    exp_q.delete();
    m_err = 0; m_sticky = 0; m_errc = 0; m_wrapc = 0;
    #1;

    // lock acquisition: locked after sample 2, expected 4 after sample 3
    do_reset();
    send(7'd0); send(7'd1); send(7'd2);
    check("lock_after_2", 32'(bus.locked), 32'd1);
    send(7'd3);
    check("expected_4", 32'(bus.expected), 32'd4);

    // wrap while locked
    do_reset();
    send(7'd124); send(7'd125); send(7'd126); send(7'd127); send(7'd0);
    check("wrap_once", 32'(bus.wrap_count), 32'd1);
    send(7'd1);
    check("expected_after_wrap", 32'(bus.expected), 32'd2);

    // mismatch and relock: expected 5, feed 9,10,11
    do_reset();
    send(7'd2); send(7'd3); send(7'd4);
    send(7'd9);
    check("err_pulse", 32'(bus.err), 32'd1);
    send(7'd10);
    check("err_one_cycle", 32'(bus.err), 32'd0);
    send(7'd11);
    check("relocked", 32'(bus.locked), 32'd1);
    check("sticky_kept", 32'(bus.err_sticky), 32'd1);

    // gaps during SYNC and LOCKED, then a SYNC mismatch
    do_reset();
    send(7'd10); gap(); send(7'd11); gap(); gap(); send(7'd12); gap(); send(7'd13); gap();
    send(7'd20); send(7'd21); send(7'd50); send(7'd51); gap(); send(7'd52); send(7'd53);

    // saturation: 300 locked mismatches, each followed by a two-value relock
    gen = 7'd54;
    for (int i = 0; i < 300; i++) begin
      bad = gen + 7'd50;
      send(bad);
      send(bad + 7'd1);
      send(bad + 7'd2);
      gen = bad + 7'd3;
    end
    check("err_saturated", 32'(bus.err_count), 32'd255);
    bad = gen + 7'd33;
    step(1'b0, 1'b1, bad, 1'b1);
    check("clr_vs_err_count", 32'(bus.err_count), 32'd1);
    check("clr_vs_err_sticky", 32'(bus.err_sticky), 32'd1);
    send(bad + 7'd1); send(bad + 7'd2);
    step(1'b0, 1'b0, '0, 1'b1);

    // reset mid-LOCKED with in_valid high, then sample 40
    send(bad + 7'd3);
    step(1'b1, 1'b1, bad + 7'd4, 1'b0);
    send(7'd40);
    check("expected_41", 32'(bus.expected), 32'd41);

    // randomized stream with gaps, breaks, clears and occasional resets
    gen = 7'($urandom_range(0, 127));
    for (int i = 0; i < 3000; i++) begin
      logic r, v, c;
      logic [WIDTH-1:0] q;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0);
      q = ($urandom_range(0, 11) == 0) ? 7'($urandom_range(0, 127)) : gen;
      step(r, v, q, c);
      if (v) gen = q + 7'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
